// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared types and helpers for the Monte Carlo linear-combination evaluator.
//   mc_state_e : batch controller states (IDLE, RUN, DRAIN, DONE)
//   mc_t_w     : width of t = a*x + b*y, sized so the sum can never wrap
// ---------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

  // Each product is width+coef_w bits; one extra bit holds the carry of the sum.
  function automatic int mc_t_w(input int width, input int coef_w);
    return width + coef_w + 1;
  endfunction

endpackage

// File: rtl/mc_lincomb_pipe.sv
// ---------------------------------------------------------------------------
// mc_lincomb_pipe
// Two-stage pipeline computing t = a*x + b*y and the hit flag (t <= threshold).
//   Stage 1 registers the two products, stage 2 registers t and the hit flag.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid             sample entering stage 1 this cycle
//   in_x, in_y           sample operands (WIDTH, unsigned)
//   coef_a, coef_b       coefficients (COEF_W, unsigned)
//   threshold            hit bound (T_W)
//   s1_valid             stage-1 valid flag
//   out_valid            stage-2 valid flag (t/hit are meaningful)
//   t, hit               registered result and comparison
// ---------------------------------------------------------------------------
module mc_lincomb_pipe #(
  parameter int WIDTH  = 10,
  parameter int COEF_W = 4,
  parameter int T_W    = WIDTH + COEF_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_y,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [T_W-1:0]    threshold,
  output logic              s1_valid,
  output logic              out_valid,
  output logic [T_W-1:0]    t,
  output logic              hit
);

  localparam int P_W = WIDTH + COEF_W;

  logic [P_W-1:0] prod_a_q, prod_a_d;
  logic [P_W-1:0] prod_b_q, prod_b_d;
  logic           v1_q, v1_d;
  logic [T_W-1:0] t_q, t_d;
  logic           hit_q, hit_d;
  logic           v2_q, v2_d;

  // Data registers only load when their stage carries a sample, so bubbles
  // leave the previous values in place and only the valid flags move.
  always_comb begin
    prod_a_d = prod_a_q;
    prod_b_d = prod_b_q;
    t_d      = t_q;
    hit_d    = hit_q;
    v1_d     = in_valid;
    v2_d     = v1_q;
    if (in_valid) begin
      prod_a_d = P_W'(in_x) * P_W'(coef_a);
      prod_b_d = P_W'(in_y) * P_W'(coef_b);
    end
    if (v1_q) begin
      t_d   = T_W'(prod_a_q) + T_W'(prod_b_q);
      hit_d = (t_d <= threshold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
      v1_q     <= 1'b0;
      t_q      <= '0;
      hit_q    <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      v1_q     <= v1_d;
      t_q      <= t_d;
      hit_q    <= hit_d;
      v2_q     <= v2_d;
    end
  end

  assign s1_valid  = v1_q;
  assign out_valid = v2_q;
  assign t         = t_q;
  assign hit       = hit_q;

endmodule

// File: rtl/mc_lincomb_accum.sv
// ---------------------------------------------------------------------------
// mc_lincomb_accum
// Batch Monte Carlo evaluator: streams (x, y) samples through a two-stage
// a*x + b*y pipeline, counts samples with t <= threshold over a batch.
// Optional feature macro: MC_TMAX_TRACK_EN builds a running maximum of t;
// without it t_max is tied to 0.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a batch (only honoured in IDLE)
//   num_samples          batch size, latched on start
//   coef_a, coef_b       coefficients, latched on start
//   threshold            hit bound, latched on start
//   s_valid/s_ready      sample handshake; s_ready depends only on state/count
//   s_x, s_y             sample operands
//   busy                 high outside IDLE
//   done                 one-cycle pulse at batch end
//   hits, total          hit count and accumulated-sample count
//   t_max                maximum t in the batch (0 when tracking is disabled)
// ---------------------------------------------------------------------------
module mc_lincomb_accum
  import mc_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int COEF_W = 4,
  parameter int CNT_W  = 32,
  parameter int T_W    = mc_t_w(WIDTH, COEF_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [T_W-1:0]    threshold,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_x,
  input  logic [WIDTH-1:0]  s_y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  total,
  output logic [T_W-1:0]    t_max
);

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [COEF_W-1:0] coef_a_q, coef_a_d;
  logic [COEF_W-1:0] coef_b_q, coef_b_d;
  logic [T_W-1:0]    thr_q, thr_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pipe_s1_valid;
  logic              pipe_out_valid;
  logic [T_W-1:0]    pipe_t;
  logic              pipe_hit;

  // Ready is a pure function of state and accept counter so that an upstream
  // source may wait for ready before raising valid without deadlock.
  assign s_ready = (state_q == ST_RUN) && (acc_cnt_q < num_q);
  assign accept  = s_valid && s_ready;

  mc_lincomb_pipe #(
    .WIDTH  (WIDTH),
    .COEF_W (COEF_W),
    .T_W    (T_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_x      (s_x),
    .in_y      (s_y),
    .coef_a    (coef_a_q),
    .coef_b    (coef_b_q),
    .threshold (thr_q),
    .s1_valid  (pipe_s1_valid),
    .out_valid (pipe_out_valid),
    .t         (pipe_t),
    .hit       (pipe_hit)
  );

`ifdef MC_TMAX_TRACK_EN
  logic [T_W-1:0] t_max_q, t_max_d;
`else
  logic unused_pipe_t;
  assign unused_pipe_t = ^pipe_t;
`endif

  // Controller next state and accumulation. Accumulation is written first so
  // that the start-time clear in IDLE takes priority; the pipeline is always
  // empty in IDLE, so the two never actually collide.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    coef_a_d  = coef_a_q;
    coef_b_d  = coef_b_q;
    thr_d     = thr_q;
    acc_cnt_d = acc_cnt_q;
    hits_d    = hits_q;
    total_d   = total_q;
`ifdef MC_TMAX_TRACK_EN
    t_max_d   = t_max_q;
`endif

    if (pipe_out_valid) begin
      hits_d  = hits_q + CNT_W'(pipe_hit);
      total_d = total_q + CNT_W'(1);
`ifdef MC_TMAX_TRACK_EN
      if (pipe_t > t_max_q) t_max_d = pipe_t;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_samples;
          coef_a_d  = coef_a;
          coef_b_d  = coef_b;
          thr_d     = threshold;
          acc_cnt_d = '0;
          hits_d    = '0;
          total_d   = '0;
`ifdef MC_TMAX_TRACK_EN
          t_max_d   = '0;
`endif
          state_d   = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_d == num_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pipe_s1_valid && !pipe_out_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy/done are registered copies of the next state, so they line up
    // exactly with the state register.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      coef_a_q  <= '0;
      coef_b_q  <= '0;
      thr_q     <= '0;
      acc_cnt_q <= '0;
      hits_q    <= '0;
      total_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MC_TMAX_TRACK_EN
      t_max_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      coef_a_q  <= coef_a_d;
      coef_b_q  <= coef_b_d;
      thr_q     <= thr_d;
      acc_cnt_q <= acc_cnt_d;
      hits_q    <= hits_d;
      total_q   <= total_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MC_TMAX_TRACK_EN
      t_max_q   <= t_max_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hits  = hits_q;
  assign total = total_q;
`ifdef MC_TMAX_TRACK_EN
  assign t_max = t_max_q;
`else
  assign t_max = '0;
`endif

endmodule

// File: tb/tb_mc_lincomb_accum.sv
// ---------------------------------------------------------------------------
// tb_mc_lincomb_accum
// Directed self-checking bench for mc_lincomb_accum. Inputs are driven and
// outputs observed on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_mc_lincomb_accum;

  localparam int WIDTH  = 10;
  localparam int COEF_W = 4;
  localparam int CNT_W  = 32;
  localparam int T_W    = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic [COEF_W-1:0] coef_a = '0;
  logic [COEF_W-1:0] coef_b = '0;
  logic [T_W-1:0]    threshold = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [WIDTH-1:0]  s_x = '0;
  logic [WIDTH-1:0]  s_y = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  hits;
  logic [CNT_W-1:0]  total;
  logic [T_W-1:0]    t_max;

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] xs [0:31];
  logic [WIDTH-1:0] ys [0:31];

  // Stream results
  int ready_cycles, k_last, k_done, extra_acc;

  mc_lincomb_accum #(
    .WIDTH (WIDTH), .COEF_W (COEF_W), .CNT_W (CNT_W), .T_W (T_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .num_samples (num_samples),
    .coef_a (coef_a), .coef_b (coef_b), .threshold (threshold),
    .s_valid (s_valid), .s_ready (s_ready), .s_x (s_x), .s_y (s_y),
    .busy (busy), .done (done), .hits (hits), .total (total), .t_max (t_max)
  );

  always #5 clk = ~clk;

  // Drive the batch parameters and raise start for one rising edge; the
  // stream task lowers start on the following falling edge.
  task automatic start_batch(input int n, input int a, input int b, input int thr);
    @(negedge clk);
    num_samples = CNT_W'(n);
    coef_a      = COEF_W'(a);
    coef_b      = COEF_W'(b);
    threshold   = T_W'(thr);
    start       = 1'b1;
  endtask

  // Feed xs/ys[0..n-1] until done is seen (bounded). toggle randomises
  // s_valid and keeps s_valid high once all samples are sent, to probe for
  // extra acceptances. abort_at stops feeding after that many acceptances.
  task automatic run_stream(input int n, input bit toggle, input int abort_at,
                            input bit inject_start);
    int idx;
    bit acc;
    idx = 0;
    ready_cycles = 0; k_last = -1; k_done = -1; extra_acc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject_start && k == 5) begin
        start = 1'b1;
        num_samples = CNT_W'(3);
      end
      if (done) begin
        k_done = k;
        break;
      end
      if (abort_at >= 0 && idx == abort_at) break;
      if (s_ready) ready_cycles++;
      if (idx < n) begin
        s_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        s_x = xs[idx];
        s_y = ys[idx];
      end else begin
        s_valid = toggle;
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) begin
        if (idx < n) begin
          idx++;
          k_last = k;
        end else begin
          extra_acc++;
        end
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (abort_at < 0 && k_done < 0) begin
      compared++; mismatched++;
      $display("[TB] FAIL stream_timeout: done not seen, accepted %0d of %0d", idx, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    compared++; if (hits !== '0) begin mismatched++; $display("[TB] FAIL reset_hits: got %0d expected 0", hits); end
    compared++; if (total !== '0) begin mismatched++; $display("[TB] FAIL reset_total: got %0d expected 0", total); end
    compared++; if (t_max !== '0) begin mismatched++; $display("[TB] FAIL reset_t_max: got %0d expected 0", t_max); end
    rst_n = 1'b1;
  endtask

  task automatic test_hit_boundary();
    // t = 2*100 + 3*50 = 350
    xs[0] = 10'd100; ys[0] = 10'd50; xs[1] = 10'd100; ys[1] = 10'd50;
    start_batch(2, 2, 3, 350);
    run_stream(2, 1'b0, -1, 1'b0);
    compared++; if (hits !== 32'd2) begin mismatched++; $display("[TB] FAIL boundary_eq_hits: got %0d expected 2", hits); end
    compared++; if (total !== 32'd2) begin mismatched++; $display("[TB] FAIL boundary_eq_total: got %0d expected 2", total); end
    start_batch(2, 2, 3, 349);
    run_stream(2, 1'b0, -1, 1'b0);
    compared++; if (hits !== 32'd0) begin mismatched++; $display("[TB] FAIL boundary_lt_hits: got %0d expected 0", hits); end
    compared++; if (total !== 32'd2) begin mismatched++; $display("[TB] FAIL boundary_lt_total: got %0d expected 2", total); end
  endtask

  task automatic test_max_operands();
    logic [T_W-1:0] exp_tmax;
    xs[0] = 10'd1023; ys[0] = 10'd1023;
    start_batch(1, 15, 15, 30690);
    run_stream(1, 1'b0, -1, 1'b0);
`ifdef MC_TMAX_TRACK_EN
    exp_tmax = 15'd30690;
`else
    exp_tmax = 15'd0;
`endif
    compared++; if (hits !== 32'd1) begin mismatched++; $display("[TB] FAIL max_hits: got %0d expected 1", hits); end
    compared++; if (total !== 32'd1) begin mismatched++; $display("[TB] FAIL max_total: got %0d expected 1", total); end
    compared++; if (t_max !== exp_tmax) begin mismatched++; $display("[TB] FAIL max_t_max: got %0d expected %0d", t_max, exp_tmax); end
  endtask

  task automatic test_streaming();
    // a=b=1, threshold 500: even samples t=200 (hit), odd samples t=600 (miss)
    for (int i = 0; i < 8; i++) begin
      xs[i] = (i % 2 == 0) ? 10'd100 : 10'd400;
      ys[i] = (i % 2 == 0) ? 10'd100 : 10'd200;
    end
    start_batch(8, 1, 1, 500);
    run_stream(8, 1'b0, -1, 1'b0);
    compared++; if (ready_cycles !== 8) begin mismatched++; $display("[TB] FAIL stream_ready_cycles: got %0d expected 8", ready_cycles); end
    compared++; if (k_done - k_last - 1 !== 3) begin mismatched++; $display("[TB] FAIL stream_done_latency: got %0d expected 3", k_done - k_last - 1); end
    compared++; if (hits !== 32'd4) begin mismatched++; $display("[TB] FAIL stream_hits: got %0d expected 4", hits); end
    compared++; if (total !== 32'd8) begin mismatched++; $display("[TB] FAIL stream_total: got %0d expected 8", total); end
    @(negedge clk);
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_done_pulse_width: got %b expected 0", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_idle_after_done: got busy %b expected 0", busy); end
    repeat (3) @(negedge clk);
    compared++; if (hits !== 32'd4) begin mismatched++; $display("[TB] FAIL stream_hits_hold: got %0d expected 4", hits); end
  endtask

  task automatic test_back_pressure();
    int exp_hits, t, exp_tmax;
    exp_hits = 0; exp_tmax = 0;
    for (int i = 0; i < 16; i++) begin
      xs[i] = WIDTH'((i * 37) % 1024);
      ys[i] = WIDTH'((i * 91 + 5) % 1024);
      t = 3 * ((i * 37) % 1024) + 5 * ((i * 91 + 5) % 1024);
      if (t <= 4000) exp_hits++;
      if (t > exp_tmax) exp_tmax = t;
    end
`ifndef MC_TMAX_TRACK_EN
    exp_tmax = 0;
`endif
    start_batch(16, 3, 5, 4000);
    run_stream(16, 1'b1, -1, 1'b1);
    compared++; if (hits !== CNT_W'(exp_hits)) begin mismatched++; $display("[TB] FAIL bp_hits: got %0d expected %0d", hits, exp_hits); end
    compared++; if (total !== 32'd16) begin mismatched++; $display("[TB] FAIL bp_total: got %0d expected 16", total); end
    compared++; if (extra_acc !== 0) begin mismatched++; $display("[TB] FAIL bp_extra_accept: got %0d expected 0", extra_acc); end
    compared++; if (t_max !== T_W'(exp_tmax)) begin mismatched++; $display("[TB] FAIL bp_t_max: got %0d expected %0d", t_max, exp_tmax); end
  endtask

  task automatic test_zero_length();
    start_batch(0, 2, 3, 350);
    run_stream(0, 1'b0, -1, 1'b0);
    compared++; if (k_done !== 0) begin mismatched++; $display("[TB] FAIL zero_done_cycle: got %0d expected 0", k_done); end
    compared++; if (ready_cycles !== 0) begin mismatched++; $display("[TB] FAIL zero_s_ready: got %0d expected 0", ready_cycles); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_s_ready_done: got %b expected 0", s_ready); end
    compared++; if (hits !== 32'd0) begin mismatched++; $display("[TB] FAIL zero_hits: got %0d expected 0", hits); end
    compared++; if (total !== 32'd0) begin mismatched++; $display("[TB] FAIL zero_total: got %0d expected 0", total); end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    for (int i = 0; i < 10; i++) begin xs[i] = 10'd100; ys[i] = 10'd50; end
    start_batch(10, 2, 3, 350);
    run_stream(10, 1'b0, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_s_ready: got %b expected 0", s_ready); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    compared++; if (hits !== '0) begin mismatched++; $display("[TB] FAIL midrst_hits: got %0d expected 0", hits); end
    compared++; if (total !== '0) begin mismatched++; $display("[TB] FAIL midrst_total: got %0d expected 0", total); end
    compared++; if (t_max !== '0) begin mismatched++; $display("[TB] FAIL midrst_t_max: got %0d expected 0", t_max); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    compared++; if (done_seen !== 0) begin mismatched++; $display("[TB] FAIL midrst_stale_activity: got %0d expected 0", done_seen); end
    start_batch(2, 2, 3, 350);
    run_stream(2, 1'b0, -1, 1'b0);
    compared++; if (hits !== 32'd2) begin mismatched++; $display("[TB] FAIL midrst_new_hits: got %0d expected 2", hits); end
    compared++; if (total !== 32'd2) begin mismatched++; $display("[TB] FAIL midrst_new_total: got %0d expected 2", total); end
  endtask

  initial begin
    test_reset();
    test_hit_boundary();
    test_max_operands();
    test_streaming();
    test_back_pressure();
    test_zero_length();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_lincomb_accum.md
# mc_lincomb_accum

Batch Monte Carlo evaluator: streams (x, y) samples, computes t = a·x + b·y with run-time coefficients in a two-stage pipeline, compares t against a threshold, and counts hits over a programmed batch size. It is the parametrised successor of the fixed-coefficient linear function block. It sits between the random-sample generator and the result readout logic.

## Interface
- WIDTH, 10: sample width of x and y (unsigned).
- COEF_W, 4: coefficient width of a and b (unsigned).
- CNT_W, 32: width of the batch-size and hit counters.
- T_W (derived, WIDTH+COEF_W+1): width of t and threshold.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a batch; honoured only in IDLE.
- num_samples  in  CNT_W  batch size; latched on start.
- coef_a, coef_b  in  COEF_W  coefficients; latched on start.
- threshold  in  T_W  hit bound; latched on start.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- s_x, s_y  in  WIDTH  sample operands.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at batch end.
- hits  out  CNT_W  samples with t <= threshold.
- total  out  CNT_W  samples accumulated.
- t_max  out  T_W  maximum t in the batch (see Configuration).

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
- IDLE → RUN on start: latch num_samples, coefficients and threshold; clear hits, total, t_max and the accept counter.
- IDLE → DONE directly when start arrives with num_samples == 0.
- RUN: s_ready = (accepted < num_samples). s_ready is a function of state and counter only and never depends on s_valid.
- RUN → DRAIN on the edge that accepts the last sample.
- DRAIN → DONE when both pipeline valid flags are 0.
- DONE: done = 1 for that cycle, then → IDLE.
- start is ignored in RUN, DRAIN and DONE.
- Arithmetic is unsigned throughout.
  - Products are WIDTH+COEF_W bits. Their sum is T_W bits and cannot overflow.
  - A sample is a hit when t <= threshold, inclusive.
- hits <= total <= num_samples, so the counters need no saturation.
- hits, total and t_max hold their values after DONE until the next accepted start.
- Reset mid-batch: state returns to IDLE, pipeline valid flags clear, and the batch is discarded with no done pulse.
- Reset value of every output is 0, including s_ready.

## Timing
- Sample accepted at edge E: products are registered at E.
- At E+1: t and the hit flag are registered.
- At E+2: hits, total and t_max update.
- Throughput is one sample per cycle when s_valid is held high.
- Stalls (s_valid low) insert bubbles. A bubble never changes the counters.
- Last sample accepted at edge E: DONE is entered at E+3, done is high for the cycle E+3..E+4, and the FSM is in IDLE at E+4.
- With num_samples == 0 and start at edge S: done is high for the cycle S..S+1 and hits = total = 0.

## Configuration
- MC_TMAX_TRACK_EN defined:
  - A T_W register captures the maximum t among accumulated samples.
  - It clears on start and updates in the accumulation stage.
- MC_TMAX_TRACK_EN undefined:
  - No register is built.
  - t_max is tied to 0.
  - The port is still present, so the interface does not change.

## Structure
- Package mc_pkg holds:
  - the FSM state enum typedef;
  - a localparam function computing T_W from WIDTH and COEF_W.
- One sub-module, mc_lincomb_pipe, contains the two-stage multiply/add/compare pipeline with its valid flags.
  - It outputs hit, t and out_valid.
  - Control and counters stay in the top module.

## Test plan
- Hit boundary: WIDTH=10, a=2, b=3, x=100, y=50 (t=350), num_samples=2.
  - With threshold=350: hits=2, total=2.
  - Repeat with threshold=349: hits=0, total=2.
- Maximum operands: x=y=1023, a=b=15 gives t=30690 with no wrap.
  - threshold=30690 → hit.
  - With the macro: t_max=30690.
- Streaming: 8 back-to-back samples alternating hit and miss, s_valid held high.
  - s_ready is high for exactly 8 cycles.
  - done is high 3 cycles after the last acceptance edge.
  - hits=4, total=8.
- Back-pressure: s_valid toggled pseudo-randomly over 16 samples.
  - Counts match the reference model.
  - No sample is accepted after the 16th.
  - start pulsed during RUN has no effect.
- Zero-length batch: num_samples=0.
  - done pulses on the cycle after the start edge.
  - s_ready is never high.
  - hits = total = 0.
- Reset mid-run: rst_n asserted asynchronously after 3 of 10 samples.
  - All outputs read 0 immediately and state is IDLE.
  - A new batch then completes correctly with no done pulse from the aborted one.
